uart_tx_arbiter: RTL and testbench

Shares one fractional-divider UART transmitter between N byte-stream requesters (monitor console, debug dumper, status reporter, ...). Arbitrates round-robin at message granularity: a granted requester owns the transmitter until it sends a byte flagged `last` or stalls longer than a timeout. A one-byte output register decouples requester timing from the UART's `valid`/`ready` interface.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between N byte-stream requesters, the shared UART transmitter and grant status.
// The arbiter takes the slave view; requesters/UART stub take the master view.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           timeout;

    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_valid, grant_id, timeout
    );

    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_valid, grant_id, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter between N requesters,
// with a one-byte output register and a stall timeout that revokes a silent owner's grant.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 65535,
    localparam int IDW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    uart_tx_arbiter_if.slave bus
);
    localparam int            TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] prev_q, prev_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           last_q, last_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [IDW-1:0] winner;
    logic [N-1:0]   req_ready_w;
    logic           timeout_w;
    logic           owner_valid;
    logic           owner_last;
    logic [7:0]     owner_data;

    // Scan offsets from far to near so the nearest requester after prev wins.
    always_comb begin
        winner = prev_q;
        for (int i = N; i >= 1; i--) begin
            if (bus.req_valid[(int'(prev_q) + i) % N])
                winner = IDW'((int'(prev_q) + i) % N);
        end
    end

    assign owner_valid = bus.req_valid[owner_q];
    assign owner_last  = bus.req_last[owner_q];
    assign owner_data  = bus.req_data[8*int'(owner_q) +: 8];

    for (genvar g = 0; g < N; g++) begin : g_ready
        assign req_ready_w[g] = (state_q == BUSY) && !tx_valid_q && (owner_q == IDW'(g));
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prev_d     = prev_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        last_d     = last_q;
        timer_d    = timer_q;
        timeout_w  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d = winner;
                    prev_d  = winner;
                    timer_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!tx_valid_q) begin
                    // A byte arriving in the expiry cycle still wins over the timeout.
                    if (owner_valid) begin
                        tx_data_d  = owner_data;
                        tx_valid_d = 1'b1;
                        last_d     = owner_last;
                        timer_d    = '0;
                    end else if (TIMEOUT != 0 && timer_q == TMAX) begin
                        timeout_w = 1'b1;
                        state_d   = IDLE;
                    end else if (timer_q != TMAX) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (last_q)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            prev_q     <= IDW'(N - 1);
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prev_q     <= prev_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.req_ready   = req_ready_w;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.grant_valid = (state_q == BUSY);
    assign bus.grant_id    = owner_q;
    assign bus.timeout     = timeout_w;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted requester streams, a stub UART with a
// programmable busy time, and hand-computed expected byte/grant sequences.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(.N(N), .TIMEOUT(20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] s_data [N][8];
    logic       s_last [N][8];
    int         s_len  [N];
    int         s_ptr  [N];
    logic [N-1:0] s_mask;

    int   hold;
    int   hold_cfg;
    logic uart_block;

    logic [7:0]     tx_log_d [$];
    logic [IDW-1:0] tx_log_id [$];
    int             grant_log [$];
    logic           gv_prev;
    logic           post_xfer_gv;
    int             cyc_cnt = 0;
    int             xfer_cyc;
    int             to_cnt;
    int             to_cyc;

    task automatic put(input int i, input logic [7:0] d, input logic l);
        s_data[i][s_len[i]] = d;
        s_last[i][s_len[i]] = l;
        s_len[i]++;
    endtask

    task automatic apply_reqs();
        logic [8*N-1:0] d;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        d = '0; v = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            if (s_mask[i] && s_ptr[i] < s_len[i]) begin
                v[i]         = 1'b1;
                l[i]         = s_last[i][s_ptr[i]];
                d[8*i +: 8]  = s_data[i][s_ptr[i]];
            end
        end
        bus.req_data  = d;
        bus.req_valid = v;
        bus.req_last  = l;
    endtask

    // One clock: record handshakes seen before the edge, update stimulus, sample after settle.
    task automatic cycle();
        logic [N-1:0]   acc;
        logic           xf;
        logic [7:0]     xd;
        logic [IDW-1:0] xid;
        acc = resetn ? (bus.req_valid & bus.req_ready) : '0;
        xf  = resetn && bus.tx_valid && bus.tx_ready;
        xd  = bus.tx_data;
        xid = bus.grant_id;
        @(posedge clk);
        #1;
        cyc_cnt++;
        for (int i = 0; i < N; i++)
            if (acc[i]) s_ptr[i]++;
        if (xf) begin
            tx_log_d.push_back(xd);
            tx_log_id.push_back(xid);
            xfer_cyc = cyc_cnt;
            hold = hold_cfg;
        end else if (hold > 0) begin
            hold--;
        end
        bus.tx_ready = (hold == 0) && !uart_block;
        apply_reqs();
        #1;
        if (bus.grant_valid === 1'b1 && !gv_prev) grant_log.push_back(int'(bus.grant_id));
        gv_prev = (bus.grant_valid === 1'b1);
        if (bus.timeout === 1'b1) begin
            to_cnt++;
            if (to_cnt == 1) to_cyc = cyc_cnt;
        end
        if (xf) post_xfer_gv = bus.grant_valid;
    endtask

    task automatic clear_logs();
        tx_log_d.delete();
        tx_log_id.delete();
        grant_log.delete();
        to_cnt = 0;
        to_cyc = 0;
        xfer_cyc = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            s_len[i] = 0;
            s_ptr[i] = 0;
        end
        s_mask     = '1;
        hold       = 0;
        hold_cfg   = 0;
        uart_block = 1'b0;
        bus.tx_ready = 1'b1;
        apply_reqs();
        resetn = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
        gv_prev = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", bus.grant_valid); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    endtask

    task automatic test_single();
        int n;
        logic [7:0] exp_d [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        hold_cfg = 10;
        put(1, 8'h41, 1'b0);
        put(1, 8'h42, 1'b0);
        put(1, 8'h43, 1'b1);
        apply_reqs();
        #1;
        cycle();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", bus.req_ready); end
        checks++; if (bus.grant_id !== 2'd1 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL single_grant: got v=%b id=%0d want v=1 id=1", bus.grant_valid, bus.grant_id); end
        cycle();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin errors++; $display("FAIL single_first_byte: got v=%b d=%h want v=1 d=41", bus.tx_valid, bus.tx_data); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_full: got %b want 0000", bus.req_ready); end
        n = 0;
        while (tx_log_d.size() < 3 && n < 200) begin cycle(); n++; end
        checks++; if (tx_log_d.size() != 3) begin errors++; $display("FAIL single_count: got %0d bytes want 3", tx_log_d.size()); end
        for (int k = 0; k < 3 && k < tx_log_d.size(); k++) begin
            checks++; if (tx_log_d[k] !== exp_d[k] || tx_log_id[k] !== 2'd1) begin errors++; $display("FAIL single_byte%0d: got %h id %0d want %h id 1", k, tx_log_d[k], tx_log_id[k], exp_d[k]); end
        end
        checks++; if (post_xfer_gv !== 1'b0) begin errors++; $display("FAIL single_release: grant_valid %b after last transfer want 0", post_xfer_gv); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [7:0] exp_d [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
        int exp_g [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) s_len[i] = 0;
        put(0, 8'h01, 1'b0); put(0, 8'h02, 1'b1); put(0, 8'h03, 1'b0); put(0, 8'h04, 1'b1);
        put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b1);
        put(2, 8'h21, 1'b0); put(2, 8'h22, 1'b1);
        put(3, 8'h31, 1'b0); put(3, 8'h32, 1'b1);
        resetn = 1'b0;
        s_mask = '1;
        for (int i = 0; i < N; i++) s_ptr[i] = 0;
        hold = 0; hold_cfg = 0; uart_block = 1'b0; bus.tx_ready = 1'b1;
        apply_reqs();
        cycle();
        cycle();
        resetn = 1'b1;
        gv_prev = 1'b0;
        clear_logs();
        n = 0;
        while (tx_log_d.size() < 10 && n < 300) begin cycle(); n++; end
        checks++; if (tx_log_d.size() != 10) begin errors++; $display("FAIL rr_count: got %0d bytes want 10", tx_log_d.size()); end
        for (int k = 0; k < 10 && k < tx_log_d.size(); k++) begin
            checks++; if (tx_log_d[k] !== exp_d[k]) begin errors++; $display("FAIL rr_byte%0d: got %h want %h", k, tx_log_d[k], exp_d[k]); end
        end
        checks++; if (grant_log.size() != 5) begin errors++; $display("FAIL rr_grants: got %0d grants want 5", grant_log.size()); end
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            checks++; if (grant_log[k] != exp_g[k]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", k, grant_log[k], exp_g[k]); end
        end
    endtask

    task automatic test_timeout();
        int n;
        int e;
        do_reset();
        put(2, 8'h10, 1'b0);
        put(3, 8'h30, 1'b1);
        apply_reqs();
        #1;
        n = 0;
        while (tx_log_d.size() < 1 && n < 50) begin cycle(); n++; end
        e = xfer_cyc;
        n = 0;
        while (tx_log_d.size() < 2 && n < 200) begin cycle(); n++; end
        checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_pulse_cycles: got %0d want 1", to_cnt); end
        checks++; if (to_cyc - e != 20) begin errors++; $display("FAIL to_delay: got %0d cycles want 20", to_cyc - e); end
        checks++; if (tx_log_d.size() != 2) begin errors++; $display("FAIL to_count: got %0d bytes want 2", tx_log_d.size()); end
        if (tx_log_d.size() == 2) begin
            checks++; if (tx_log_d[0] !== 8'h10 || tx_log_id[0] !== 2'd2) begin errors++; $display("FAIL to_byte0: got %h id %0d want 10 id 2", tx_log_d[0], tx_log_id[0]); end
            checks++; if (tx_log_d[1] !== 8'h30 || tx_log_id[1] !== 2'd3) begin errors++; $display("FAIL to_byte1: got %h id %0d want 30 id 3", tx_log_d[1], tx_log_id[1]); end
        end
        checks++; if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 3) begin errors++; $display("FAIL to_grants: got %0d grants first %0d want 2 grants 2,3", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1); end
    endtask

    task automatic test_timeout_race();
        int n;
        int e;
        do_reset();
        put(2, 8'h20, 1'b0);
        put(2, 8'h21, 1'b1);
        apply_reqs();
        #1;
        cycle();
        cycle();
        s_mask[2] = 1'b0;
        apply_reqs();
        #1;
        n = 0;
        while (tx_log_d.size() < 1 && n < 20) begin cycle(); n++; end
        e = xfer_cyc;
        n = 0;
        while (cyc_cnt < e + 19 && n < 40) begin cycle(); n++; end
        s_mask[2] = 1'b1;
        cycle();
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL race_no_pulse: got timeout %b want 0", bus.timeout); end
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL race_ready: got %b want 0100", bus.req_ready); end
        cycle();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h21) begin errors++; $display("FAIL race_accept: got v=%b d=%h want v=1 d=21", bus.tx_valid, bus.tx_data); end
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin errors++; $display("FAIL race_grant: got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id); end
        n = 0;
        while (tx_log_d.size() < 2 && n < 20) begin cycle(); n++; end
        checks++; if (to_cnt != 0) begin errors++; $display("FAIL race_to_count: got %0d pulses want 0", to_cnt); end
    endtask

    task automatic test_slow_uart();
        int n;
        int bad_to;
        int bad_rdy;
        int bad_tx;
        do_reset();
        uart_block = 1'b1;
        bus.tx_ready = 1'b0;
        put(0, 8'h5a, 1'b1);
        put(1, 8'h6b, 1'b1);
        apply_reqs();
        #1;
        cycle();
        cycle();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5a) begin errors++; $display("FAIL slow_load: got v=%b d=%h want v=1 d=5a", bus.tx_valid, bus.tx_data); end
        bad_to = 0; bad_rdy = 0; bad_tx = 0;
        for (int c = 0; c < 1000; c++) begin
            cycle();
            if (bus.timeout !== 1'b0) bad_to++;
            if (bus.req_ready !== 4'b0000) bad_rdy++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5a) bad_tx++;
        end
        checks++; if (bad_to != 0) begin errors++; $display("FAIL slow_timeout: %0d cycles with timeout want 0", bad_to); end
        checks++; if (bad_rdy != 0) begin errors++; $display("FAIL slow_ready: %0d cycles with req_ready set want 0", bad_rdy); end
        checks++; if (bad_tx != 0) begin errors++; $display("FAIL slow_hold: %0d cycles with byte not held want 0", bad_tx); end
        uart_block = 1'b0;
        bus.tx_ready = 1'b1;
        n = 0;
        while (tx_log_d.size() < 2 && n < 50) begin cycle(); n++; end
        checks++; if (tx_log_d.size() != 2 || tx_log_d[0] !== 8'h5a || tx_log_d[1] !== 8'h6b) begin errors++; $display("FAIL slow_drain: got %0d bytes want 5a,6b", tx_log_d.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        uart_block = 1'b1;
        bus.tx_ready = 1'b0;
        put(1, 8'h77, 1'b1);
        put(0, 8'h66, 1'b1);
        put(3, 8'h33, 1'b1);
        s_mask = 4'b0010;
        apply_reqs();
        #1;
        cycle();
        cycle();
        checks++; if (bus.tx_valid !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL mid_setup: got v=%b id=%0d want v=1 id=1", bus.tx_valid, bus.grant_id); end
        s_mask = 4'b1011;
        apply_reqs();
        #1;
        resetn = 1'b0;
        cycle();
        checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx: got v=%b d=%h want v=0 d=00", bus.tx_valid, bus.tx_data); end
        checks++; if (bus.req_ready !== 4'b0000 || bus.timeout !== 1'b0) begin errors++; $display("FAIL mid_ready: got rdy=%b to=%b want 0000,0", bus.req_ready, bus.timeout); end
        checks++; if (bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: got v=%b id=%0d want v=0 id=0", bus.grant_valid, bus.grant_id); end
        resetn = 1'b1;
        grant_log.delete();
        cycle();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_rearb: got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id); end
        uart_block = 1'b0;
        bus.tx_ready = 1'b1;
        n = 0;
        while (tx_log_d.size() < 2 && n < 100) begin cycle(); n++; end
        checks++; if (tx_log_d.size() != 2) begin errors++; $display("FAIL mid_count: got %0d bytes want 2", tx_log_d.size()); end
        if (tx_log_d.size() == 2) begin
            checks++; if (tx_log_d[0] !== 8'h66 || tx_log_d[1] !== 8'h33) begin errors++; $display("FAIL mid_bytes: got %h,%h want 66,33", tx_log_d[0], tx_log_d[1]); end
        end
    endtask

    initial begin
        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        gv_prev       = 1'b0;
        post_xfer_gv  = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_timeout_race();
        test_slow_uart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
